// File: rtl/ip_pwm_decoder.sv
// Second-order CIC (sinc2) decimator turning a first-order delta-sigma bit stream into 17-bit signed samples.
// Optional saturation flag output enabled by defining IP_PWM_DECODER_CLIP_EN.
module ip_pwm_decoder #(
  parameter int DECIM_LOG2 = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pwm_wave,
  output logic [16:0] signal_level,
`ifdef IP_PWM_DECODER_CLIP_EN
  output logic        signal_clip,
`endif
  output logic        signal_valid
);

  localparam int W  = 2 * DECIM_LOG2 + 1;
  localparam int SH = 17 - 2 * DECIM_LOG2;

  typedef enum logic [1:0] {WARMUP0, WARMUP1, RUN} state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          integ1_q, integ1_d;
  logic [W-1:0]          integ2_q, integ2_d;
  logic [W-1:0]          dly1_q, dly1_d;
  logic [W-1:0]          dly2_q, dly2_d;
  logic [W-1:0]          acc_q, acc_d;
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic [16:0]           level_q, level_d;
  logic                  valid_q, valid_d;
  logic [W-1:0]          comb1, comb2;
  logic [17:0]           acc_sh;
  logic                  boundary;
  logic                  sat;
`ifdef IP_PWM_DECODER_CLIP_EN
  logic                  clip_q, clip_d;
`endif

  always_comb begin
    state_d  = state_q;
    integ1_d = integ1_q;
    integ2_d = integ2_q;
    dly1_d   = dly1_q;
    dly2_d   = dly2_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    pend_d   = 1'b0;
    level_d  = level_q;
    valid_d  = pend_q;
    boundary = enable && (cnt_q == '1);

    if (enable) begin
      integ1_d = integ1_q + {{(W-1){1'b0}}, pwm_wave};
      integ2_d = integ2_q + integ1_d;
      cnt_d    = cnt_q + 1'b1;
    end

    // Modulo arithmetic in the combs cancels any integrator wrap.
    comb1 = integ2_d - dly1_q;
    comb2 = comb1 - dly2_q;

    if (boundary) begin
      dly1_d = integ2_d;
      dly2_d = comb1;
      acc_d  = comb2;
      pend_d = (state_q == RUN);
      case (state_q)
        WARMUP0: state_d = WARMUP1;
        WARMUP1: state_d = RUN;
        default: state_d = RUN;
      endcase
    end

    // acc only reaches 2^17 after the shift at full scale; anything below
    // maps to signed by flipping the MSB (subtracting 65536).
    acc_sh = 18'(acc_q) << SH;
    sat    = acc_sh[17];
    if (pend_q) begin
      level_d = sat ? 17'h0FFFF : {~acc_sh[16], acc_sh[15:0]};
    end
  end

`ifdef IP_PWM_DECODER_CLIP_EN
  always_comb begin
    clip_d = clip_q;
    if (pend_q) clip_d = sat;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= WARMUP0;
      integ1_q <= '0;
      integ2_q <= '0;
      dly1_q   <= '0;
      dly2_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      level_q  <= 17'h00000;
      valid_q  <= 1'b0;
`ifdef IP_PWM_DECODER_CLIP_EN
      clip_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      integ1_q <= integ1_d;
      integ2_q <= integ2_d;
      dly1_q   <= dly1_d;
      dly2_q   <= dly2_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
`ifdef IP_PWM_DECODER_CLIP_EN
      clip_q   <= clip_d;
`endif
    end
  end

  assign signal_level = level_q;
  assign signal_valid = valid_q;
`ifdef IP_PWM_DECODER_CLIP_EN
  assign signal_clip  = clip_q;
`endif

endmodule

// File: tb/tb_ip_pwm_decoder.sv
// Scoreboard bench for ip_pwm_decoder: a triangular-weight sinc2 reference predicts each sample and its due cycle.
module tb_ip_pwm_decoder;

  localparam int L = 6;
  localparam int R = 1 << L;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        pwm_wave = 1'b0;
  logic [16:0] signal_level;
  logic        signal_valid;
`ifdef IP_PWM_DECODER_CLIP_EN
  logic        signal_clip;
`endif

  ip_pwm_decoder #(.DECIM_LOG2(L)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pwm_wave     (pwm_wave),
    .signal_level (signal_level),
`ifdef IP_PWM_DECODER_CLIP_EN
    .signal_clip  (signal_clip),
`endif
    .signal_valid (signal_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int level;
    int clip;
    bit rng;
  } exp_t;

  exp_t sb[$];
  bit   hist[$];
  int   nbits = 0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_level = 0;
  bit   rng_mode = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: sample = sum of the last 2R bits weighted 1..R..1 (sinc2 impulse response).
  task automatic model_bit(input bit b);
    int acc;
    int lvl;
    int clp;
    hist.push_front(b);
    if (hist.size() > 2 * R) void'(hist.pop_back());
    nbits++;
    if ((nbits % R) == 0 && nbits >= 3 * R) begin
      acc = 0;
      for (int d = 0; d < hist.size(); d++)
        acc += int'(hist[d]) * ((d < R) ? d + 1 : 2 * R - 1 - d);
      lvl = acc * (1 << (17 - 2 * L)) - 65536;
      clp = (lvl > 65535) ? 1 : 0;
      if (clp != 0) lvl = 65535;
      sb.push_back('{due: cyc + 2, level: lvl, clip: clp, rng: rng_mode});
    end
  endtask

  task automatic drive(input bit en, input bit b);
    @(negedge clk);
    enable   = en;
    pwm_wave = b;
    if (en) model_bit(b);
  endtask

  task automatic do_reset(input bit idle_first);
    if (idle_first) repeat (4) drive(1'b0, 1'b0);
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    sb.delete();
    hist.delete();
    nbits = 0;
    #1;
    chk("rst_level", int'(signal_level), 0);
    chk("rst_valid", int'(signal_valid), 0);
`ifdef IP_PWM_DECODER_CLIP_EN
    chk("rst_clip", int'(signal_clip), 0);
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   lv;
    if (reset) begin
      last_level = 0;
    end else begin
      lv = int'($signed(signal_level));
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("valid_missing", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (signal_valid) begin
        if (sb.size() == 0) begin
          chk("valid_spurious", int'(signal_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("valid_time", cyc, e.due);
          chk("level", lv, e.level);
`ifdef IP_PWM_DECODER_CLIP_EN
          chk("clip", int'(signal_clip), e.clip);
`endif
          if (e.rng) chk("dsm_range", ((lv - 16384 <= 512) && (16384 - lv <= 512)) ? 1 : 0, 1);
        end
        last_level = lv;
      end else begin
        chk("hold", lv, last_level);
      end
    end
  end

  initial begin
    int dsm_int;
    int saved;
    bit b;

    repeat (3) @(negedge clk);
    do_reset(1'b0);

    // Constant 0: -65536 every R clocks, first one 3R+1 clocks after release.
    repeat (6 * R) drive(1'b1, 1'b0);

    do_reset(1'b1);
    repeat (6 * R) drive(1'b1, 1'b1);

    do_reset(1'b1);
    for (int i = 0; i < 6 * R; i++) drive(1'b1, (i % 2) == 0);

    // Loopback from a first-order delta-sigma modulator at +16384.
    do_reset(1'b1);
    rng_mode = 1'b1;
    dsm_int  = 0;
    for (int i = 0; i < 7 * R; i++) begin
      b = (dsm_int >= 0);
      dsm_int += 16384 - (b ? 65536 : -65536);
      drive(1'b1, b);
    end
    rng_mode = 1'b0;

    // Enable every third clock.
    do_reset(1'b1);
    for (int i = 0; i < 3 * 6 * R; i++) drive((i % 3) == 2, 1'b0);

    // Long idle: nothing moves.
    saved = int'($signed(signal_level));
    repeat (1000) drive(1'b0, 1'b1);
    chk("idle_hold", int'($signed(signal_level)), saved);

    // Random bits with random enable.
    do_reset(1'b1);
    for (int i = 0; i < 12 * R; i++) drive($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1);

    // Reset 40 bits into a RUN block, then warm-up must restart.
    do_reset(1'b1);
    repeat (4 * R + 40) drive(1'b1, 1'b1);
    do_reset(1'b0);
    repeat (3 * R + 2 * R) drive(1'b1, 1'b1);

    repeat (4) drive(1'b0, 1'b0);
    chk("drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ip_pwm_decoder.md
IP_PWM_DECODER -- requirements
Module: ip_pwm_decoder

Interface
REQ-001 Parameter DECIM_LOG2, default 6, log2 of the decimation ratio R (R = 2^DECIM_LOG2); legal range 4..8.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-high.
REQ-004 enable  input  1  bit strobe; pwm_wave is sampled only on cycles with enable=1.
REQ-005 pwm_wave  input  1  first-order delta-sigma bit stream (1 = positive full scale, 0 = negative full scale).
REQ-006 signal_level  output  17  signed two's-complement decoded sample, registered.
REQ-007 signal_valid  output  1  one-clock pulse marking a new signal_level.
REQ-008 signal_clip  output  1  present only with IP_PWM_DECODER_CLIP_EN; set when the current sample was saturated.

Function
REQ-009 The filter SHALL be a second-order CIC (sinc2): two cascaded integrators, decimation by R, two cascaded combs.
REQ-010 Integrators, comb delays and the comb result SHALL be (2*DECIM_LOG2+1) bits wide and unsigned, with modulo wrap-around; wrap SHALL NOT corrupt the result.
REQ-011 Input to integrator 1 SHALL be 1 for pwm_wave=1 and 0 for pwm_wave=0.
REQ-012 On enable=0 cycles, integrators, the bit counter, comb delays and the state SHALL hold.
REQ-013 A bit counter (DECIM_LOG2 bits) SHALL advance on each enable cycle and wrap from R-1 to 0; the enable cycle at count R-1 is the decimation boundary.
REQ-014 At the boundary, the post-update integrator-2 value SHALL enter the comb stage; the comb result acc lies in 0..R^2.
REQ-015 Output value = (acc shifted left by 17-2*DECIM_LOG2) - 65536, saturated to -65536..+65535 (acc = R^2 gives +65535).
REQ-016 signal_level and signal_valid SHALL update on the clock edge following the boundary cycle (latency 1 clock); signal_valid is high for exactly one clock.
REQ-017 signal_level SHALL hold between valid pulses.
REQ-018 State machine WARMUP0 -> WARMUP1 -> RUN, advancing one state per boundary; boundaries in WARMUP0/WARMUP1 SHALL update comb delays but SHALL NOT pulse signal_valid or change signal_level.
REQ-019 In RUN every boundary SHALL produce one valid sample; RUN is left only by reset.
REQ-020 First valid pulse SHALL occur one clock after the 3R-th enabled bit following reset release.
REQ-021 enable held high every clock SHALL be supported (valid pulse at most every R clocks).

Reset
REQ-022 On reset: integrators, comb delays, bit counter = 0; state = WARMUP0; signal_level = 17'h00000; signal_valid = 0; signal_clip = 0.
REQ-023 Reset asserted mid-decimation SHALL discard partial data immediately; warm-up restarts per REQ-020.

Configuration
REQ-024 Macro IP_PWM_DECODER_CLIP_EN defined: signal_clip exists, registered with signal_level, = 1 when REQ-015 saturation occurred for that sample, else 0; holds between valid pulses.
REQ-025 Macro not defined: signal_clip port and its logic are absent; all other behaviour identical.

Verification (DECIM_LOG2=6, R=64)
REQ-026 Constant pwm_wave=0, enable every clock -> first valid at clock 193 after reset release, signal_level = -65536 (17'h10000) every 64 clocks, signal_clip=0.
REQ-027 Constant pwm_wave=1 -> signal_level = +65535 (17'h0FFFF) per valid; signal_clip=1 when macro defined.
REQ-028 Alternating 1,0 -> signal_level = 0 on every valid sample.
REQ-029 Loopback from the existing 17-bit delta-sigma modulator driven with constant +16384, shared enable -> every RUN sample within 16384 ± 512.
REQ-030 enable pulsed every 3rd clock -> valid pulse every 192 clocks, same values as REQ-026; enable held low 1000 clocks -> no valid, outputs held.
REQ-031 Reset asserted at bit count 40 of RUN -> outputs zero immediately; next valid only after 192 further enabled bits.
